// File: rtl/dm_pkg.sv
// ---------------------------------------------------------------------------
// dm_pkg -- shared debug-module types used on the DMI path.
//
// Contents:
//   dtm_op_e                  DMI operation code (NOP / READ / WRITE)
//   dmi_req_t                 41-bit request  {addr[6:0], op[1:0], data[31:0]}
//   dmi_resp_t                34-bit response {data[31:0], resp[1:0]}
//   DTM_SUCCESS/DTM_ERR/...   DMI response codes
//   DmiLockedReadMaskDefault  registers readable while the JTAG port is locked
//                             (dmcontrol 0x10, dmstatus 0x11, hartinfo 0x12)
// ---------------------------------------------------------------------------
package dm;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_e;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_SUCCESS = 2'h0;
    localparam logic [1:0] DTM_ERR     = 2'h2;
    localparam logic [1:0] DTM_BUSY    = 2'h3;

    localparam logic [127:0] DmiLockedReadMaskDefault = 128'h0007_0000;

endpackage : dm

// File: rtl/dmi_access_gate.sv
// ---------------------------------------------------------------------------
// dmi_access_gate -- DMI policy stage between the DTM (after its CDC) and the
// debug module.
//
// Every upstream request is qualified against the JTAG unlock status sampled
// at accept time. While locked, only reads of registers flagged in
// LockedReadMask reach the debug module; everything else is answered locally
// with DTM_ERR. One transaction is in flight at a time, and a transaction
// that spends TimeoutCycles in Fwd+WaitResp is answered locally with DTM_ERR
// so a hung debug module cannot wedge the DTM.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   unlock_i                     JTAG unlock status (sampled at accept only)
//   req_i/req_valid_i/req_ready_o     upstream request channel
//   resp_o/resp_valid_o/resp_ready_i  upstream response channel
//   dm_req_o/dm_req_valid_o/dm_req_ready_i     request to debug module
//   dm_resp_i/dm_resp_valid_i/dm_resp_ready_o  response from debug module
//   blocked_o                    one-cycle pulse per rejected request
//   timeout_o                    one-cycle pulse per timed-out transaction
//   blocked_cnt_o                saturating count of rejected requests
// ---------------------------------------------------------------------------
module dmi_access_gate
    import dm::*;
#(
    parameter int unsigned    TimeoutCycles  = 1024,  // must be >= 2
    parameter logic [127:0]   LockedReadMask = DmiLockedReadMaskDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        unlock_i,
    input  dmi_req_t    req_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output dmi_resp_t   resp_o,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output dmi_req_t    dm_req_o,
    output logic        dm_req_valid_o,
    input  logic        dm_req_ready_i,
    input  dmi_resp_t   dm_resp_i,
    input  logic        dm_resp_valid_i,
    output logic        dm_resp_ready_o,
    output logic        blocked_o,
    output logic        timeout_o,
    output logic [7:0]  blocked_cnt_o
);

    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StFwd      = 2'd1;
    localparam logic [1:0] StWaitResp = 2'd2;
    localparam logic [1:0] StResp     = 2'd3;

    localparam dmi_resp_t ErrResp = '{data: 32'h0, resp: DTM_ERR};

    logic [1:0]      state_q, state_d;
    dmi_req_t        req_q, req_d;
    dmi_resp_t       resp_q, resp_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]      blocked_cnt_q, blocked_cnt_d;
    logic            blocked_q, blocked_d;
    logic            timeout_q, timeout_d;

    logic allowed;
    logic tmo_expired;

    assign allowed = unlock_i | ((req_i.op == DTM_READ) & LockedReadMask[req_i.addr]);

    // ">=" rather than "==": a Fwd handshake on the last counted cycle carries
    // the counter to TimeoutCycles, and WaitResp must still time out from there.
    assign tmo_expired = (tmo_cnt_q >= TmoLast);

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        req_d         = req_q;
        resp_d        = resp_q;
        tmo_cnt_d     = tmo_cnt_q;
        blocked_cnt_d = blocked_cnt_q;
        blocked_d     = 1'b0;
        timeout_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    req_d = req_i;
                    if (allowed) begin
                        state_d   = StFwd;
                        tmo_cnt_d = '0;
                    end else begin
                        resp_d    = ErrResp;
                        state_d   = StResp;
                        blocked_d = 1'b1;
                        if (blocked_cnt_q != 8'hFF) blocked_cnt_d = blocked_cnt_q + 8'd1;
                    end
                end
            end
            StFwd: begin
                // Completion beats timeout when both land on the same cycle.
                if (dm_req_ready_i) begin
                    state_d   = StWaitResp;
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end else if (tmo_expired) begin
                    // Dropping dm_req_valid_o here is the only valid withdrawal.
                    resp_d    = ErrResp;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StWaitResp: begin
                if (dm_resp_valid_i) begin
                    resp_d  = dm_resp_i;
                    state_d = StResp;
                end else if (tmo_expired) begin
                    resp_d    = ErrResp;
                    timeout_d = 1'b1;
                    state_d   = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                end
            end
            StResp: begin
                if (resp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            req_q         <= '0;
            resp_q        <= '0;
            tmo_cnt_q     <= '0;
            blocked_cnt_q <= '0;
            blocked_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            resp_q        <= resp_d;
            tmo_cnt_q     <= tmo_cnt_d;
            blocked_cnt_q <= blocked_cnt_d;
            blocked_q     <= blocked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign req_ready_o     = (state_q == StIdle);
    assign dm_req_valid_o  = (state_q == StFwd);
    assign dm_req_o        = req_q;
    // Idle also accepts so late responses after a timeout are drained.
    assign dm_resp_ready_o = (state_q == StIdle) | (state_q == StWaitResp);
    assign resp_valid_o    = (state_q == StResp);
    assign resp_o          = resp_q;
    assign blocked_o       = blocked_q;
    assign timeout_o       = timeout_q;
    assign blocked_cnt_o   = blocked_cnt_q;

endmodule : dmi_access_gate

// File: tb/tb_dmi_access_gate.sv
// ---------------------------------------------------------------------------
// tb_dmi_access_gate -- self-checking bench for dmi_access_gate
// (TimeoutCycles = 16, default locked-read allowlist).
// A transaction-level reference model tracks what the gate must present each
// cycle; a negedge process compares every output against it, and the
// directed stimulus adds literal spot checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmi_access_gate;
    import dm::*;

    localparam int Tmo = 16;

    logic        clk;
    logic        rst_i;
    logic        unlock_i;
    dmi_req_t    req_i;
    logic        req_valid_i;
    logic        req_ready_o;
    dmi_resp_t   resp_o;
    logic        resp_valid_o;
    logic        resp_ready_i;
    dmi_req_t    dm_req_o;
    logic        dm_req_valid_o;
    logic        dm_req_ready_i;
    dmi_resp_t   dm_resp_i;
    logic        dm_resp_valid_i;
    logic        dm_resp_ready_o;
    logic        blocked_o;
    logic        timeout_o;
    logic [7:0]  blocked_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dmi_access_gate #(.TimeoutCycles(Tmo)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .unlock_i        (unlock_i),
        .req_i           (req_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .resp_o          (resp_o),
        .resp_valid_o    (resp_valid_o),
        .resp_ready_i    (resp_ready_i),
        .dm_req_o        (dm_req_o),
        .dm_req_valid_o  (dm_req_valid_o),
        .dm_req_ready_i  (dm_req_ready_i),
        .dm_resp_i       (dm_resp_i),
        .dm_resp_valid_i (dm_resp_valid_i),
        .dm_resp_ready_o (dm_resp_ready_o),
        .blocked_o       (blocked_o),
        .timeout_o       (timeout_o),
        .blocked_cnt_o   (blocked_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Locked reads are allowed only for dmcontrol/dmstatus/hartinfo.
    function automatic bit locked_read_ok(input logic [6:0] a);
        return (a >= 7'h10) && (a <= 7'h12);
    endfunction

    bit        model_live = 1'b0;
    bit        m_busy, m_at_dm, m_waiting, m_have_resp;
    bit        m_blk_pulse, m_tmo_pulse;
    int        m_spent;          // cycles spent in flight, counting the current one
    logic [7:0] m_blk_cnt;
    dmi_req_t  m_req;
    dmi_resp_t m_resp;

    always @(posedge clk) begin
        m_blk_pulse <= 1'b0;
        m_tmo_pulse <= 1'b0;
        if (rst_i) begin
            model_live  <= 1'b1;
            m_busy      <= 1'b0;
            m_at_dm     <= 1'b0;
            m_waiting   <= 1'b0;
            m_have_resp <= 1'b0;
            m_spent     <= 0;
            m_blk_cnt   <= 8'd0;
        end else if (!m_busy) begin
            if (req_valid_i) begin
                m_req  <= req_i;
                m_busy <= 1'b1;
                if (unlock_i || (req_i.op == DTM_READ && locked_read_ok(req_i.addr))) begin
                    m_at_dm <= 1'b1;
                    m_spent <= 1;
                end else begin
                    m_have_resp <= 1'b1;
                    m_resp      <= '{data: 32'h0, resp: 2'h2};
                    m_blk_pulse <= 1'b1;
                    if (m_blk_cnt != 8'd255) m_blk_cnt <= m_blk_cnt + 8'd1;
                end
            end
        end else if (m_have_resp) begin
            if (resp_ready_i) begin
                m_busy      <= 1'b0;
                m_have_resp <= 1'b0;
            end
        end else if (m_at_dm && dm_req_ready_i) begin
            m_at_dm   <= 1'b0;
            m_waiting <= 1'b1;
            m_spent   <= m_spent + 1;
        end else if (m_waiting && dm_resp_valid_i) begin
            m_waiting   <= 1'b0;
            m_have_resp <= 1'b1;
            m_resp      <= dm_resp_i;
        end else if (m_spent >= Tmo) begin
            m_at_dm     <= 1'b0;
            m_waiting   <= 1'b0;
            m_have_resp <= 1'b1;
            m_resp      <= '{data: 32'h0, resp: 2'h2};
            m_tmo_pulse <= 1'b1;
        end else begin
            m_spent <= m_spent + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_live) begin
            check("req_ready_o",     req_ready_o,     !m_busy);
            check("resp_valid_o",    resp_valid_o,    m_have_resp);
            check("dm_req_valid_o",  dm_req_valid_o,  m_at_dm);
            check("dm_resp_ready_o", dm_resp_ready_o, !m_busy || m_waiting);
            check("blocked_o",       blocked_o,       m_blk_pulse);
            check("timeout_o",       timeout_o,       m_tmo_pulse);
            check("blocked_cnt_o",   blocked_cnt_o,   m_blk_cnt);
            if (m_have_resp) check("resp_o", resp_o, m_resp);
            if (m_at_dm)     check("dm_req_o", dm_req_o, m_req);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_i           = 1'b1;
        unlock_i        = 1'b0;
        req_i           = '0;
        req_valid_i     = 1'b0;
        resp_ready_i    = 1'b1;
        dm_req_ready_i  = 1'b1;
        dm_resp_i       = '0;
        dm_resp_valid_i = 1'b0;
        step();
        step();
        check("reset req_ready",    req_ready_o,     1'b1);
        check("reset dm_resp_rdy",  dm_resp_ready_o, 1'b1);
        check("reset blocked_cnt",  blocked_cnt_o,   8'd0);
        rst_i = 1'b0;
        step();

        // 1: locked read of dmstatus is forwarded
        req_i = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
        req_valid_i = 1'b1;
        step();                                   // cycle 1
        req_valid_i = 1'b0;
        check("t1 dm_req_valid c1", dm_req_valid_o, 1'b1);
        step();                                   // cycle 2
        dm_resp_i = '{data: 32'h0000_0C82, resp: 2'h0};
        dm_resp_valid_i = 1'b1;
        step();                                   // cycle 3
        dm_resp_valid_i = 1'b0;
        check("t1 resp_valid c3", resp_valid_o, 1'b1);
        check("t1 resp_o",        resp_o, {32'h0000_0C82, 2'b00});
        check("t1 blocked_cnt",   blocked_cnt_o, 8'd0);
        step();

        // 2: locked write is rejected locally
        req_i = '{addr: 7'h10, op: DTM_WRITE, data: 32'h1};
        req_valid_i = 1'b1;
        step();                                   // cycle 1
        req_valid_i = 1'b0;
        check("t2 resp_valid c1", resp_valid_o, 1'b1);
        check("t2 resp_o",        resp_o, {32'h0, 2'h2});
        check("t2 blocked_o",     blocked_o, 1'b1);
        check("t2 blocked_cnt",   blocked_cnt_o, 8'd1);
        step();
        check("t2 blocked_o off", blocked_o, 1'b0);

        // 3: unlocked write, debug module stalls 5 cycles; unlock drops mid-flight
        unlock_i = 1'b1;
        req_i = '{addr: 7'h04, op: DTM_WRITE, data: 32'hDEAD_BEEF};
        req_valid_i = 1'b1;
        dm_req_ready_i = 1'b0;
        step();
        req_valid_i = 1'b0;
        unlock_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t3 dm_req_o held", dm_req_o, {7'h04, 2'h2, 32'hDEAD_BEEF});
            step();
        end
        dm_req_ready_i = 1'b1;
        step();
        dm_resp_i = '{data: 32'h5A5A_0001, resp: 2'h0};
        dm_resp_valid_i = 1'b1;
        step();
        dm_resp_valid_i = 1'b0;
        check("t3 resp_o", resp_o, {32'h5A5A_0001, 2'b00});
        step();

        // 4: debug module never answers -> timeout after 16 cycles in flight
        unlock_i = 1'b1;
        req_i = '{addr: 7'h20, op: DTM_READ, data: 32'h0};
        req_valid_i = 1'b1;
        step();                                   // cycle 1
        req_valid_i = 1'b0;
        repeat (15) step();                       // cycle 16
        check("t4 no resp c16",  resp_valid_o, 1'b0);
        check("t4 no tmo c16",   timeout_o, 1'b0);
        step();                                   // cycle 17
        check("t4 resp_valid",   resp_valid_o, 1'b1);
        check("t4 resp_o",       resp_o, {32'h0, 2'h2});
        check("t4 timeout_o",    timeout_o, 1'b1);
        step();                                   // Idle
        dm_resp_i = '{data: 32'hFFFF_FFFF, resp: 2'h0};
        dm_resp_valid_i = 1'b1;
        check("t4 late drain rdy", dm_resp_ready_o, 1'b1);
        step();
        dm_resp_valid_i = 1'b0;
        check("t4 late no resp", resp_valid_o, 1'b0);
        step();

        // 5: upstream holds resp_ready low 10 cycles; extra requests ignored
        unlock_i = 1'b0;
        resp_ready_i = 1'b0;
        req_i = '{addr: 7'h05, op: DTM_WRITE, data: 32'h0};
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i >= 3 && i <= 5) begin
                req_i = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
                req_valid_i = 1'b1;
            end else begin
                req_valid_i = 1'b0;
            end
            check("t5 resp held",  resp_o, {32'h0, 2'h2});
            check("t5 req_ready",  req_ready_o, 1'b0);
            step();
        end
        req_valid_i = 1'b0;
        resp_ready_i = 1'b1;
        check("t5 blocked_cnt", blocked_cnt_o, 8'd2);
        step();
        step();
        check("t5 no fwd", dm_req_valid_o, 1'b0);

        // 6: reset during WaitResp, then 300 blocked requests
        unlock_i = 1'b1;
        req_i = '{addr: 7'h11, op: DTM_READ, data: 32'h0};
        req_valid_i = 1'b1;
        step();
        req_valid_i = 1'b0;
        step();                                   // WaitResp
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t6 rst req_ready",  req_ready_o,     1'b1);
        check("t6 rst resp_valid", resp_valid_o,    1'b0);
        check("t6 rst dm_valid",   dm_req_valid_o,  1'b0);
        check("t6 rst dm_rrdy",    dm_resp_ready_o, 1'b1);
        check("t6 rst cnt",        blocked_cnt_o,   8'd0);
        step();
        step();
        check("t6 no resp", resp_valid_o, 1'b0);

        unlock_i = 1'b0;
        req_i = '{addr: 7'h30, op: DTM_WRITE, data: 32'h0};
        req_valid_i = 1'b1;
        repeat (600) step();
        req_valid_i = 1'b0;
        check("t6 cnt saturated", blocked_cnt_o, 8'd255);
        step();
        step();
        check("t6 idle after", req_ready_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_dmi_access_gate

// File: doc/dmi_access_gate.md
Name: dmi_access_gate

Overview:
- Core-side DMI policy stage between the JTAG DTM's clock-domain-crossed request/response outputs and the debug module (dm_top).
- Qualifies every DMI request against the JTAG unlock status:
  - Locked: only reads of an allowlisted register set are forwarded.
  - Everything else is answered locally with an error response.
- Enforces one outstanding transaction and a response timeout so a hung debug module cannot wedge the DTM.

Parameters:
- TimeoutCycles, 1024: maximum cycles in Fwd+WaitResp before a local error response is generated; must be ≥2.
- LockedReadMask, 128'h0007_0000 (bits 16,17,18 = dmcontrol, dmstatus, hartinfo): per-DMI-address bit; 1 = read permitted while locked.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  reset; synchronous, active-high
- unlock_i  in  1  JTAG unlock status from the DTM password check; sampled only at request accept
- req_i  in  dm::dmi_req_t (41)  upstream request {addr[6:0], op[1:0], data[31:0]}
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- resp_o  out  dm::dmi_resp_t (34)  upstream response {data[31:0], resp[1:0]}
- resp_valid_o  out  1  upstream response valid
- resp_ready_i  in  1  upstream response ready
- dm_req_o  out  dm::dmi_req_t (41)  request to debug module
- dm_req_valid_o  out  1  request valid to debug module
- dm_req_ready_i  in  1  debug module ready
- dm_resp_i  in  dm::dmi_resp_t (34)  debug module response
- dm_resp_valid_i  in  1  debug module response valid
- dm_resp_ready_o  out  1  response ready to debug module
- blocked_o  out  1  one-cycle pulse per rejected request
- timeout_o  out  1  one-cycle pulse per timed-out transaction
- blocked_cnt_o  out  8  saturating count of rejected requests

Behaviour:
- FSM states: Idle, Fwd, WaitResp, Resp. Registers: req_q, resp_q, tmo_cnt (width $clog2(TimeoutCycles+1)), blocked_cnt.
- Reset (rst_i high at a clk_i edge):
  - state = Idle; req_q, resp_q, tmo_cnt and blocked_cnt = 0.
  - Outputs: req_ready_o = 1, resp_valid_o = 0, dm_req_valid_o = 0, dm_resp_ready_o = 1, blocked_o = 0, timeout_o = 0.
  - Reset mid-transaction abandons it silently; no response is ever produced for it.
- Idle:
  - req_ready_o = 1. On req_valid_i, latch req_i into req_q.
  - allowed = unlock_i | (op == DTM_READ & LockedReadMask[addr]).
  - allowed: next state Fwd, tmo_cnt cleared.
  - not allowed: resp_q = {32'h0, DTM_ERR (2'h2)}, next state Resp, blocked_o pulses next cycle, blocked_cnt += 1 (saturates at 255).
  - NOP (op 0) requests are policy-checked like any other.
- Fwd:
  - dm_req_valid_o = 1, dm_req_o = req_q, held stable until dm_req_ready_i.
  - On dm_req_ready_i: next state WaitResp.
- WaitResp:
  - dm_resp_ready_o = 1. On dm_resp_valid_i: resp_q = dm_resp_i, next state Resp.
- Timeout:
  - tmo_cnt increments in Fwd and WaitResp.
  - When tmo_cnt == TimeoutCycles-1 and no completing handshake occurs that cycle: resp_q = {32'h0, DTM_ERR}, timeout_o pulses, next state Resp.
  - If completion and timeout coincide, completion wins.
  - Timeout in Fwd withdraws dm_req_valid_o. This is the sole permitted valid-withdrawal.
- Resp:
  - resp_valid_o = 1, resp_o = resp_q, held until resp_ready_i.
  - Handshake → Idle; req_ready_o reasserts the following cycle.
- dm_resp_ready_o = 1 in Idle and WaitResp, 0 otherwise. Responses arriving in Idle (stale, post-timeout) are consumed and discarded.
- unlock_i changes after accept do not affect the in-flight transaction.
- Latency (request accept at cycle 0, zero-wait debug module):
  - Allowed: dm_req_valid_o at cycle 1, dm response at cycle 2, resp_valid_o at cycle 3.
  - Blocked: resp_valid_o at cycle 1.
- Throughput: one transaction in flight; upstream stalls via req_ready_o = 0 outside Idle.

Decomposition:
- dm package:
  - already holds dmi_req_t, dmi_resp_t and dtm_op_e; add DTM_ERR response code 2'h2.
  - add localparam DmiLockedReadMaskDefault.
- No sub-module: FSM, timeout counter and policy compare are one module (~180 lines).

Test Plan:
- Locked (unlock_i=0), read addr 0x11 → forwarded; dm_resp_i = {32'h0000_0C82, 0} → resp_o = {32'h0000_0C82, 0} at cycle 3; blocked_cnt_o = 0.
- Locked, write addr 0x10 data 32'h1 → dm_req_valid_o never asserts; resp_o = {0, 2} at cycle 1; blocked_o pulses; blocked_cnt_o = 1.
- Unlocked, write addr 0x04 data 32'hDEAD_BEEF with dm_req_ready_i low 5 cycles → dm_req_o stable throughout; forwarded on ready; normal response returned.
- Debug module never responds, TimeoutCycles = 16 → resp_o = {0, 2} after 16 cycles in Fwd/WaitResp; timeout_o one pulse; late dm_resp_valid_i in Idle is consumed with no upstream response.
- resp_ready_i held low 10 cycles → resp_valid_o/resp_o stable; req_ready_o = 0 and new requests are not accepted.
- rst_i asserted while in WaitResp → next cycle state Idle, all outputs at reset values; 300 blocked requests → blocked_cnt_o saturates at 255.
